alu_bist_sequencer: RTL
=======================

Name: alu_bist_sequencer

Overview:
- Hardware self-test engine for the datapath ALU. It drives the ALU's SrcA, SrcB and ALUControl inputs and checks ALUResult and Zero against an internal golden model.
- It sits beside the ALU on a test mux. It is the stimulus/checker end of the ALU interface.
- When started, it steps through every enabled op code, applying corner and pseudo-random operands at one vector per clock. It counts mismatches and records the first failing vector.

Parameters:
- N_bit, 32, ALU data width. Legal range 4..32.
- N_VEC, 16, vectors applied per op code. Legal range 4..256.
- OP_MASK, 8'b1111_0111, op enable mask; bit k enables ALUControl=k. Default skips 011.
- SEED, 32'hACE1_2468, LFSR seed. Must be nonzero.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, one-cycle request to begin a run. Honoured only in IDLE or DONE.
- SrcA, output, N_bit, operand A to the ALU.
- SrcB, output, N_bit, operand B to the ALU.
- ALUControl, output, 3, op code to the ALU.
- ALUResult, input, N_bit, ALU result (combinational from SrcA/SrcB/ALUControl).
- Zero, input, 1, ALU zero flag.
- busy, output, 1, high while vectors are being applied.
- done, output, 1, high from run completion until the next start or reset.
- pass, output, 1, equals done AND (fail_count==0).
- fail_count, output, 16, mismatching vectors counted. Saturates at 16'hFFFF.
- first_fail_op, output, 3, ALUControl of the first mismatch.
- first_fail_idx, output, 8, vector index of the first mismatch.

Behaviour:
- Reset (rst_n=0 at an edge) forces every output to 0 and the FSM to IDLE. This applies at any time, including mid-run; the partial run is discarded.
- FSM states are IDLE, RUN and DONE.
  - IDLE/DONE + start → RUN. On that edge: clear fail_count and the first_fail_* fields, drop done, load LFSR←SEED, vec_idx←0, op←lowest enabled bit of OP_MASK.
  - OP_MASK==0: start goes directly to DONE with pass=1.
  - start during RUN is ignored.
- RUN timing:
  - SrcA, SrcB and ALUControl are registered outputs and change only on edges.
  - The ALU settles within the same cycle.
  - At the next edge the sequencer compares ALUResult/Zero with the golden values for the currently driven vector, then presents the next vector.
  - Throughput is 1 vector/cycle. busy=1 for exactly popcount(OP_MASK)*N_VEC cycles.
- Vector set per op; the LFSR is reloaded to SEED at each op start:
  - idx0: A=0, B=0.
  - idx1: A=all ones, B=1.
  - idx2: A=MSB only, B=1.
  - idx≥3: A=lfsr[N_bit-1:0], B=rotl(lfsr,16)[N_bit-1:0]. The LFSR steps once per vector from idx3 onward.
- LFSR: 32-bit Galois, taps 32'h8020_0003, shift right.
- Golden model (N_bit wrap-around arithmetic):
  - 000: A&B
  - 001: A|B
  - 010: A+B
  - 011: 0
  - 100: A&~B
  - 101: A|~B
  - 110: A−B
  - 111: signed A<B → 1, else 0 (zero-extended)
  - Golden Zero = (golden result == 0).
- Mismatch: result ≠ golden OR Zero ≠ golden Zero.
  - fail_count increments, saturating.
  - The first mismatch of a run latches first_fail_op and first_fail_idx; later mismatches leave them unchanged.
- Op advance: after idx N_VEC−1, move to the next higher enabled op. After the last enabled op: busy←0, done←1, state DONE, and the outputs SrcA/SrcB/ALUControl return to 0.
- Last-vector compare and the transition to DONE occur on the same edge, so fail_count is final when done rises.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 → all outputs 0, busy=0, done=0. Release with start=0 → remains IDLE.
- Full run with N_bit=4 against a correct ALU, default mask:
  - start pulse → busy high for 112 cycles, then done=1, pass=1, fail_count=0.
  - Spot check in op 010, idx2: SrcA=1000, SrcB=0001, ALUResult=1001.
- Fault injection: bench inverts ALUResult[0] only when ALUControl==000 → done with fail_count=16, first_fail_op=000, first_fail_idx=0, pass=0.
- Zero fault: bench forces Zero=0 → first mismatch at op 000, idx0 (golden Zero=1). With N_VEC=16, fail_count equals the number of vectors across all enabled ops whose golden result is 0.
- Single op: OP_MASK=8'b1000_0000 → only ALUControl=111 is driven. idx2 (A=1000 = −8 signed, B=1) expects result 0001. busy lasts 16 cycles.
- Boundary events:
  - start pulsed mid-RUN → ignored; total busy length unchanged.
  - rst_n=0 at cycle 50 of a run → next cycle all outputs 0, state IDLE.
  - A subsequent start gives a clean run with pass=1.

Source files
------------

// File: rtl/alu_bist_sequencer.sv
// Built-in self-test sequencer for the datapath ALU: drives SrcA/SrcB/ALUControl,
// compares ALUResult/Zero against a golden model and records failures.
module alu_bist_sequencer #(
  parameter int          N_bit   = 32,
  parameter int          N_VEC   = 16,
  parameter logic [7:0]  OP_MASK = 8'b1111_0111,
  parameter logic [31:0] SEED    = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_bit-1:0] SrcA,
  output logic [N_bit-1:0] SrcB,
  output logic [2:0]       ALUControl,
  input  logic [N_bit-1:0] ALUResult,
  input  logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      fail_count,
  output logic [2:0]       first_fail_op,
  output logic [7:0]       first_fail_idx
);

  localparam logic [31:0]      LFSR_TAPS = 32'h8020_0003;
  localparam logic [7:0]       LAST_IDX  = 8'(N_VEC - 1);
  localparam logic [N_bit-1:0] ONE       = N_bit'(1);
  localparam logic [N_bit-1:0] MSB_ONLY  = {1'b1, {(N_bit-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [N_bit-1:0] r_src_a, r_src_b;
  logic [2:0]       r_op;
  logic [7:0]       r_idx;
  logic [31:0]      r_lfsr;
  logic [15:0]      r_fail_count;
  logic [2:0]       r_first_op;
  logic [7:0]       r_first_idx;

  logic [2:0]       w_first_op, w_next_op;
  logic             w_has_next;
  logic [N_bit-1:0] w_golden;
  logic             w_mismatch;
  logic [31:0]      w_lfsr_step;
  logic             w_last_vec;
  logic [7:0]       w_idx_inc;
  logic             w_start_run;

  function automatic logic [N_bit-1:0] lfsr_low(input logic [31:0] v);
    return v[N_bit-1:0];
  endfunction

  function automatic logic [N_bit-1:0] rotl16_low(input logic [31:0] v);
    logic [31:0] t;
    t = {v[15:0], v[31:16]};
    return t[N_bit-1:0];
  endfunction

  // Lowest enabled op, and the next enabled op above the one currently driven
  always_comb begin
    w_first_op = 3'd0;
    w_next_op  = 3'd0;
    w_has_next = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (OP_MASK[k]) w_first_op = 3'(k);
      if (OP_MASK[k] && (k > int'(r_op))) begin
        w_next_op  = 3'(k);
        w_has_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_golden = '0;
    case (r_op)
      3'b000:  w_golden = r_src_a & r_src_b;
      3'b001:  w_golden = r_src_a | r_src_b;
      3'b010:  w_golden = r_src_a + r_src_b;
      3'b100:  w_golden = r_src_a & ~r_src_b;
      3'b101:  w_golden = r_src_a | ~r_src_b;
      3'b110:  w_golden = r_src_a - r_src_b;
      3'b111:  w_golden = {{(N_bit-1){1'b0}}, ($signed(r_src_a) < $signed(r_src_b))};
      default: w_golden = '0;
    endcase
  end

  assign w_mismatch  = (ALUResult != w_golden) || (Zero != (w_golden == '0));
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  assign w_last_vec  = (r_idx == LAST_IDX);
  assign w_idx_inc   = r_idx + 8'd1;
  assign w_start_run = start && (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        done = (r_state == S_DONE);
        if (start) w_state_next = (OP_MASK == 8'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last_vec && !w_has_next) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Each RUN edge checks the vector on the bus, then presents the following one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_op         <= 3'd0;
      r_idx        <= 8'd0;
      r_lfsr       <= 32'd0;
      r_fail_count <= 16'd0;
      r_first_op   <= 3'd0;
      r_first_idx  <= 8'd0;
    end else if (w_start_run) begin
      r_src_a      <= '0;
      r_src_b      <= '0;
      r_op         <= w_first_op;
      r_idx        <= 8'd0;
      r_lfsr       <= SEED;
      r_fail_count <= 16'd0;
      r_first_op   <= 3'd0;
      r_first_idx  <= 8'd0;
    end else if (r_state == S_RUN) begin
      if (w_mismatch) begin
        if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
        if (r_fail_count == 16'd0) begin
          r_first_op  <= r_op;
          r_first_idx <= r_idx;
        end
      end
      if (w_last_vec) begin
        r_idx   <= 8'd0;
        r_lfsr  <= SEED;
        r_src_a <= '0;
        r_src_b <= '0;
        r_op    <= w_has_next ? w_next_op : 3'd0;
      end else begin
        r_idx <= w_idx_inc;
        case (w_idx_inc)
          8'd1: begin
            r_src_a <= '1;
            r_src_b <= ONE;
          end
          8'd2: begin
            r_src_a <= MSB_ONLY;
            r_src_b <= ONE;
          end
          default: begin
            r_src_a <= lfsr_low(r_lfsr);
            r_src_b <= rotl16_low(r_lfsr);
            r_lfsr  <= w_lfsr_step;
          end
        endcase
      end
    end
  end

  assign SrcA           = r_src_a;
  assign SrcB           = r_src_b;
  assign ALUControl     = r_op;
  assign fail_count     = r_fail_count;
  assign first_fail_op  = r_first_op;
  assign first_fail_idx = r_first_idx;
  assign pass           = done && (r_fail_count == 16'd0);

endmodule
